// File: rtl/systolic_skew_feeder_if.sv
// Fetch-side word handshake plus array-side skewed lanes, tile control and status.
interface systolic_skew_feeder_if #(
    parameter int LANES  = 32,
    parameter int DATA_W = 8
);
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    stall;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_valid;
    logic                    busy;
    logic                    tile_done;

    modport master (
        output start, in_valid, in_data, stall,
        input  in_ready, out_data, out_valid, busy, tile_done
    );

    modport slave (
        input  start, in_valid, in_data, stall,
        output in_ready, out_data, out_valid, busy, tile_done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds one tile of wide rows into the systolic west edge, lane i delayed i cycles.
// Latency: lane i of a word appears i+1 cycles after its handshake; tile_done LANES-1 cycles after the last one.
// Backpressure: stall freezes every chain, counter and transition; in_ready drops while stalled or not filling.
module systolic_skew_feeder #(
    parameter int LANES         = 32,
    parameter int DATA_W        = 8,
    parameter int ROWS_PER_TILE = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS_PER_TILE + 1);
    localparam int DRN_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_TILE - 1);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(LANES - 1);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             tile_done_q, tile_done_d;
    logic             adv;
    logic             in_hs;

    assign adv           = !bus.stall;
    assign bus.in_ready  = (state_q == FILL) && adv;
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tile_done = tile_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            // Not gated by stall so the pulse never stretches.
            tile_done_q <= tile_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tile_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (adv && bus.start) begin
                    state_d   = FILL;
                    row_cnt_d = '0;
                end
            end
            FILL: begin
                if (in_hs) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == ROW_LAST) begin
                        // A single-lane array has nothing to drain behind the last row.
                        if (LANES == 1) begin
                            state_d     = IDLE;
                            tile_done_d = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRN_INIT;
                        end
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                    if (drain_cnt_q == DRN_ONE) begin
                        state_d     = IDLE;
                        tile_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] dat_q [0:i];
        logic [i:0]        vld_q;

        // Bubble data is don't-care; only the valid bit is forced low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int j = 0; j <= i; j++) begin
                    dat_q[j] <= '0;
                end
            end else if (adv) begin
                vld_q[0] <= in_hs;
                dat_q[0] <= bus.in_data[i*DATA_W +: DATA_W];
                for (int j = 1; j <= i; j++) begin
                    vld_q[j] <= vld_q[j-1];
                    dat_q[j] <= dat_q[j-1];
                end
            end
        end

        assign bus.out_data[i*DATA_W +: DATA_W] = dat_q[i];
        assign bus.out_valid[i]                 = vld_q[i];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: table of tile scenarios plus reset corner cases, lane scoreboard.
module tb_systolic_skew_feeder;
    localparam int LANES  = 32;
    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int W      = LANES * DATA_W;
    localparam int NHIST  = 20000;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   st_hist [0:NHIST-1];

    systolic_skew_feeder_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

    systolic_skew_feeder #(
        .LANES(LANES), .DATA_W(DATA_W), .ROWS_PER_TILE(ROWS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stall value each edge actually sampled, indexed by edge number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < NHIST) st_hist[cyc+1] <= bus.stall;
    end

    // Scoreboard: accepted words with their handshake edge, a read pointer per lane.
    logic [W-1:0] wq  [$];
    int           weq [$];
    int           tdq [$];
    int           ptr [LANES];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Edge at which a word handshaken at edge e reaches lane `lane`, skipping stalled edges.
    function automatic int due_edge(input int e, input int lane);
        int ed = e;
        int k  = lane;
        while (k > 0) begin
            ed++;
            if (ed > cyc) return 1 << 30;
            if (!st_hist[ed]) k--;
        end
        return ed;
    endfunction

    function automatic logic [W-1:0] mkword(input int r);
        logic [W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*DATA_W +: DATA_W] = 8'(((r << 5) | i) & 8'hFF);
        return w;
    endfunction

    task automatic sb_flush();
        wq.delete();
        weq.delete();
        tdq.delete();
        for (int i = 0; i < LANES; i++) ptr[i] = 0;
    endtask

    always @(negedge clk) begin : mon
        logic [LANES-1:0] ev;
        logic [W-1:0]     ed;
        logic [W-1:0]     em;
        logic             etd;
        if (rst_n) begin
            ev  = '0;
            ed  = '0;
            em  = '0;
            etd = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (ptr[i] < wq.size()) begin
                    if (due_edge(weq[ptr[i]], i) <= cyc) begin
                        ev[i] = 1'b1;
                        ed[i*DATA_W +: DATA_W] = wq[ptr[i]][i*DATA_W +: DATA_W];
                        em[i*DATA_W +: DATA_W] = '1;
                    end
                end
            end
            if (tdq.size() > 0) begin
                if (due_edge(tdq[0], LANES - 1) <= cyc) begin
                    etd = 1'b1;
                    void'(tdq.pop_front());
                end
            end
            check("out_valid", W'(bus.out_valid), W'(ev));
            check("out_data", bus.out_data & em, ed);
            check("tile_done", W'(bus.tile_done), W'(etd));
            for (int i = 0; i < LANES; i++) if (ev[i] && !bus.stall) ptr[i]++;
            if (ptr[LANES-1] > 0) begin
                void'(wq.pop_front());
                void'(weq.pop_front());
                for (int i = 0; i < LANES; i++) ptr[i]--;
            end
        end
    end

    typedef struct {
        logic [15:0] pat;
        int          len;
        int          stall_at;
        int          stall_len;
        bit          start_busy;
        bit          drain_vld;
        int          done_off;
    } rec_t;

    rec_t tbl [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with start=1 already driven for the current (IDLE) cycle.
    task automatic run_tile(input int idx, input bit chain);
        rec_t         rec;
        int           rows;
        int           k;
        int           e0;
        int           el;
        int           got;
        bit           vld;
        bit           st;
        logic [W-1:0] snap_d;
        logic [W-1:0] snap_v;
        rec  = tbl[idx];
        rows = 0;
        k    = 0;
        el   = -1;
        got  = -1;
        snap_d = '0;
        snap_v = '0;
        bus.in_valid = rec.drain_vld;
        bus.in_data  = '1;
        bus.stall    = 1'b0;
        step();
        e0 = cyc + 1;
        while (rows < ROWS && k < 64) begin
            bus.start    = rec.start_busy && (k % 2 == 0);
            vld          = (k < rec.len) ? rec.pat[k] : 1'b1;
            st           = (k >= rec.stall_at) && (k < rec.stall_at + rec.stall_len);
            bus.in_valid = vld;
            bus.stall    = st;
            bus.in_data  = mkword(rows);
            if (rec.stall_len > 0 && k == rec.stall_at) begin
                snap_d = bus.out_data;
                snap_v = W'(bus.out_valid);
            end
            if (rec.stall_len > 0 && k > rec.stall_at && k <= rec.stall_at + rec.stall_len) begin
                check("stall_hold_dat", bus.out_data, snap_d);
                check("stall_hold_vld", W'(bus.out_valid), snap_v);
            end
            #1;
            check("fill_in_ready", W'(bus.in_ready), W'(!st));
            check("fill_busy", W'(bus.busy), W'(1));
            if (vld && !st) begin
                wq.push_back(mkword(rows));
                weq.push_back(cyc + 1);
                rows++;
                if (rows == ROWS) el = cyc + 1;
            end
            k++;
            step();
        end
        check("rows_accepted", W'(rows), W'(ROWS));
        if (el >= 0) tdq.push_back(el);
        bus.in_valid = rec.drain_vld;
        bus.in_data  = '1;
        bus.stall    = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.tile_done) begin
                got = cyc;
                break;
            end
            bus.start = rec.start_busy && (n % 2 == 0);
            #1;
            check("drain_in_ready", W'(bus.in_ready), W'(0));
            check("drain_busy", W'(bus.busy), W'(1));
            step();
        end
        check("done_cycle", W'(got), W'(e0 + rec.done_off));
        check("done_busy", W'(bus.busy), W'(0));
        bus.start    = chain;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        //           pat          len stall_at len  start_busy drain_vld done_off
        tbl[0] = '{16'hFFFF,      4,  0,       0,   1'b0,      1'b0,     34};
        tbl[1] = '{16'b101101,    6,  0,       0,   1'b0,      1'b0,     36};
        tbl[2] = '{16'hFFFF,      9,  2,       5,   1'b0,      1'b1,     39};
        tbl[3] = '{16'hFFFF,      4,  0,       0,   1'b1,      1'b1,     34};
        sb_flush();

        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        bus.stall    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_in_ready", W'(bus.in_ready), '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_tile_done", W'(bus.tile_done), '0);

        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            check("idle_busy", W'(bus.busy), '0);
            check("idle_in_ready", W'(bus.in_ready), '0);
        end
        bus.in_valid = 1'b0;
        step();

        bus.start = 1'b1;
        run_tile(0, 1'b1);
        run_tile(1, 1'b0);
        repeat (3) step();
        bus.start = 1'b1;
        run_tile(2, 1'b0);
        repeat (3) step();
        bus.start = 1'b1;
        run_tile(3, 1'b0);
        repeat (3) step();

        // Reset in the middle of DRAIN, with ten drain steps still to go.
        begin
            int el;
            bus.start    = 1'b1;
            bus.in_valid = 1'b0;
            step();
            bus.start = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = mkword(r);
                wq.push_back(mkword(r));
                weq.push_back(cyc + 1);
                step();
            end
            el = cyc;
            bus.in_valid = 1'b0;
            tdq.push_back(el);
            for (int n = 0; n < 100 && cyc < el + 21; n++) step();
            check("pre_rst_busy", W'(bus.busy), W'(1));
            rst_n = 1'b0;
            sb_flush();
            #1;
            check("mid_rst_out_valid", W'(bus.out_valid), '0);
            check("mid_rst_out_data", bus.out_data, '0);
            check("mid_rst_busy", W'(bus.busy), '0);
            check("mid_rst_tile_done", W'(bus.tile_done), '0);
            check("mid_rst_in_ready", W'(bus.in_ready), '0);
            repeat (3) step();
            rst_n = 1'b1;
            for (int n = 0; n < 40; n++) begin
                step();
                check("post_rst_no_done", W'(bus.tile_done), '0);
            end
        end

        bus.start = 1'b1;
        run_tile(0, 1'b0);
        repeat (40) step();
        check("sb_words_left", W'(wq.size()), '0);
        check("sb_done_left", W'(tdq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Downstream consumer of the 256-bit fetch path: accepts the wide words that the fetch/BRAM stage reads out (one matrix row of 32 INT8 elements per word) and presents them to the systolic array's west edge with diagonal skew. Lane i is delayed i cycles relative to lane 0. A tile is a fixed number of rows; after the last row the block drains the skew pipeline and pulses `tile_done`, so the controller can launch the next fetch.

## Interface
- LANES, 32, number of array rows fed (elements per word)
- DATA_W, 8, element width in bits; word width is LANES*DATA_W = 256
- ROWS_PER_TILE, 64, words accepted per tile (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- in_valid  in  1  in_data holds a valid word
- in_data  in  LANES*DATA_W  word from fetch stage; lane i = bits [i*DATA_W +: DATA_W]
- in_ready  out  1  block accepts a word this cycle
- stall  in  1  array back-pressure; freezes the skew pipeline
- out_data  out  LANES*DATA_W  skewed lanes to the array (registered)
- out_valid  out  LANES  per-lane valid (registered)
- busy  out  1  high in FILL or DRAIN
- tile_done  out  1  one-cycle pulse when the last row's lane LANES-1 is presented

## Operation
- FSM states: IDLE, FILL, DRAIN. Reset state is IDLE.
- IDLE: in_ready=0. start=1 → FILL, row_cnt←0. A start during FILL/DRAIN is ignored.
- FILL: in_ready = !stall. A handshake occurs on in_valid && in_ready. Each handshake increments row_cnt. The handshake that makes row_cnt = ROWS_PER_TILE → DRAIN, with drain_cnt←LANES-1.
- DRAIN: in_ready=0. drain_cnt decrements on each non-stalled edge. On the edge where it reaches 0 → IDLE, tile_done←1 for one cycle, busy←0.
- Skew pipeline:
  - Lane i is a shift chain of depth i+1, holding data plus a valid bit.
  - The chain advances on every edge with stall=0, in every state.
  - The input slot loads the word on a handshake; otherwise it loads a bubble (valid=0, data don't-care).
- stall=1: no chain advances. out_data, out_valid and all counters hold. No handshake occurs. FSM transitions are blocked.
- No arithmetic on data; elements pass bit-exact. row_cnt width is clog2(ROWS_PER_TILE+1); drain_cnt width is clog2(LANES).

## Timing
- Reset values: in_ready=0, busy=0, tile_done=0, out_valid=0, out_data=0, all chains cleared, row_cnt=drain_cnt=0.
- A word handshaken at edge E with no stalls after it: lane i appears on out_data/out_valid[i] in the cycle after edge E+i. Latency is 1 cycle for lane 0 and LANES cycles for lane LANES-1.
- With stalls, each stalled cycle shifts the schedule by one cycle.
- Last word handshaken at edge EL: FILL→DRAIN at EL. With no stalls, tile_done=1 and busy=0 in the cycle after EL+(LANES-1). This is the same cycle that out_valid[LANES-1] shows the last row.
- tile_done is high for exactly one cycle even if stall is asserted during that cycle.
- The earliest next start is sampled in the cycle tile_done is high. Its first handshake can occur one edge later.
- Gaps (in_valid=0 in FILL) propagate as a diagonal stripe of out_valid=0.
- rst_n low at any time (including mid-FILL or mid-DRAIN) clears everything immediately to reset values. There is no tile_done.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with in_valid=1, start=1 → all outputs 0, in_ready=0. Release, start=0 → stays IDLE, busy=0.
- Basic tile (ROWS_PER_TILE=4): start, then 4 back-to-back words, lane i byte = (r<<5)|i.
  - Lane i shows row r in the cycle after edge E0+r+i.
  - out_valid forms a diagonal ramp.
  - tile_done is a single pulse after edge E0+3+31; busy falls in the same cycle.
- Input gaps: in_valid pattern 1,0,1,1,0,1 → out_valid[i] reproduces the pattern delayed i cycles. tile_done arrives 2 cycles later than the back-to-back case.
- Stall: assert stall for 5 cycles after row 1 is accepted.
  - in_ready=0 and out_data/out_valid frozen for those 5 cycles.
  - All subsequent lane arrivals and tile_done are shifted by exactly 5 cycles.
- start during busy, and in_valid while IDLE:
  - start pulses in FILL and DRAIN have no effect on row_cnt or timing.
  - in_valid=1 in IDLE is not accepted (in_ready=0), and no bubble becomes valid.
- Reset mid-DRAIN (drain_cnt=10): assert rst_n=0 → outputs zero asynchronously, no tile_done. After release, a new tile runs correctly.
